// File: rtl/polar_pkg.sv
// Shared polar-code definitions: default code parameters, encoder state encoding,
// and the info-bit to u-vector mapping that the decoder also uses for bit extraction.
package polar_pkg;

  localparam int MAX_N = 1024;

  localparam int                DEF_N           = 8;
  localparam int                DEF_LOGN        = 3;
  localparam logic [DEF_N-1:0]  DEF_FROZEN_MASK = 8'h17;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    DONE
  } state_e;

  function automatic int count_frozen(input logic [MAX_N-1:0] mask, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && mask[i]) cnt++;
    end
    return cnt;
  endfunction

  // info[0] lands on the lowest unfrozen index, info[1] on the next, and so on.
  function automatic logic [MAX_N-1:0] map_info(input logic [MAX_N-1:0] info,
                                                input logic [MAX_N-1:0] mask,
                                                input int               n);
    logic [MAX_N-1:0] u;
    int               k;
    u = '0;
    k = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && !mask[i]) begin
        u[i] = info[k];
        k++;
      end
    end
    return u;
  endfunction

endpackage

// File: rtl/polar_encoder_xor_stage.sv
// One Arikan butterfly stage: for every i with bit s clear, v[i] ^= v[i + 2^s].
// Purely combinational; the encoder reuses this single instance for every stage.
module polar_xor_stage
  import polar_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int LOGN = DEF_LOGN
) (
  input  logic [N-1:0]    vec_in,
  input  logic [LOGN-1:0] stage,
  output logic [N-1:0]    vec_out
);

  logic [LOGN-1:0][N-1:0] stage_res;

  for (genvar s = 0; s < LOGN; s++) begin : g_stage
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> s) & 1) == 0) begin : g_upper
        assign stage_res[s][i] = vec_in[i] ^ vec_in[i + (1 << s)];
      end else begin : g_pass
        assign stage_res[s][i] = vec_in[i];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    vec_out = vec_in;
    for (int s = 0; s < LOGN; s++) begin
      if (stage == LOGN'(s)) vec_out = stage_res[s];
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Sequential polar encoder: loads info bits around the frozen set, runs LOGN
// butterfly stages one per clock, then holds the codeword on a valid/ready output.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int           N           = DEF_N,
  parameter int           LOGN        = DEF_LOGN,
  parameter logic [N-1:0] FROZEN_MASK = DEF_FROZEN_MASK,
  localparam int          K           = N - count_frozen(MAX_N'(FROZEN_MASK), N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] info_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] codeword,
  output logic         busy
);

  state_e          state_q, state_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [N-1:0]    work_q,  work_d;
  logic [N-1:0]    stage_out;
  logic [N-1:0]    u_load;

  assign u_load = N'(map_info(MAX_N'(info_bits), MAX_N'(FROZEN_MASK), N));

  polar_xor_stage #(
    .N    (N),
    .LOGN (LOGN)
  ) u_xor_stage (
    .vec_in  (work_q),
    .stage   (stage_q),
    .vec_out (stage_out)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = u_load;
          stage_d = '0;
          state_d = ENC;
        end
      end
      ENC: begin
        work_d  = stage_out;
        stage_d = stage_q + LOGN'(1);
        if (stage_q == LOGN'(LOGN - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the working register is reset too, because codeword must read 0 after reset.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign codeword  = work_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: default N=8 instance plus an N=16 instance,
// checked against a subset-XOR golden model of x = u * F^(xn).
module tb_polar_encoder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [3:0] info8;
  logic [7:0] codeword8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [7:0]  info16;
  logic [15:0] codeword16;

  localparam logic [15:0] MASK8  = 16'h0017;
  localparam logic [15:0] MASK16 = 16'h017F;

  polar_encoder dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .info_bits (info8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .codeword  (codeword8),
    .busy      (busy8)
  );

  polar_encoder #(
    .N           (16),
    .LOGN        (4),
    .FROZEN_MASK (16'h017F)
  ) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .info_bits (info16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .codeword  (codeword16),
    .busy      (busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden model: place info bits on unfrozen indices, then x_j = XOR of u_i over i that cover j.
  function automatic logic [15:0] model_encode(input int n, input logic [15:0] mask,
                                               input logic [15:0] info);
    logic [15:0] u;
    logic [15:0] x;
    logic        b;
    int          k;
    u = '0;
    x = '0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (!mask[i]) begin
        u[i] = info[k];
        k++;
      end
    end
    for (int j = 0; j < n; j++) begin
      b = 1'b0;
      for (int i = 0; i < n; i++) begin
        if ((i & j) == j) b ^= u[i];
      end
      x[j] = b;
    end
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; info8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; info16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
    n_tests++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
    n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    n_tests++; if (codeword8 !== 8'h00) begin n_fail++; $display("FAIL reset_codeword8 got=%h exp=00", codeword8); end
    n_tests++; if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || busy16 !== 1'b0 || codeword16 !== 16'h0)
      begin n_fail++; $display("FAIL reset_dut16 rdy=%b vld=%b busy=%b cw=%h exp 1 0 0 0000",
                               in_ready16, out_valid16, busy16, codeword16); end
  endtask

  task automatic test_single();
    int acc;
    in_valid8 = 1'b1; info8 = 4'b0001;
    @(negedge clk);
    in_valid8 = 1'b0; acc = cyc;
    for (int t = 0; t < 20 && out_valid8 !== 1'b1; t++) @(negedge clk);
    n_tests++; if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL single_timeout out_valid=%b exp=1", out_valid8); end
    n_tests++; if (cyc - acc !== 3) begin n_fail++; $display("FAIL single_latency got=%0d exp=3", cyc - acc); end
    n_tests++; if (codeword8 !== 8'h0F) begin n_fail++; $display("FAIL single_codeword got=%h exp=0f", codeword8); end
    n_tests++; if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin n_fail++; $display("FAIL single_done_flags busy=%b rdy=%b exp 1 0", busy8, in_ready8); end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    n_tests++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin n_fail++; $display("FAIL single_release rdy=%b vld=%b exp 1 0", in_ready8, out_valid8); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [4] = '{4'b1000, 4'b0010, 4'b1111, 4'b0000};
    logic [7:0] exps  [4] = '{8'hFF, 8'h33, 8'h96, 8'h00};
    int         acc   [4];
    out_ready8 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", w, in_ready8); end
      in_valid8 = 1'b1; info8 = words[w];
      @(negedge clk);
      in_valid8 = 1'b0; acc[w] = cyc;
      for (int t = 0; t < 20 && out_valid8 !== 1'b1; t++) @(negedge clk);
      n_tests++; if (codeword8 !== exps[w] || out_valid8 !== 1'b1)
        begin n_fail++; $display("FAIL b2b_codeword[%0d] got=%h vld=%b exp=%h", w, codeword8, out_valid8, exps[w]); end
      @(negedge clk);
    end
    out_ready8 = 1'b0;
    for (int w = 1; w < 4; w++) begin
      n_tests++; if (acc[w] - acc[w-1] !== 5) begin n_fail++; $display("FAIL b2b_spacing[%0d] got=%0d exp=5", w, acc[w] - acc[w-1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] r;
    logic [7:0] exp_cw;
    r = 4'($urandom);
    exp_cw = 8'(model_encode(8, MASK8, 16'(r)));
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; info8 = r;
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int t = 0; t < 20 && out_valid8 !== 1'b1; t++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      n_tests++; if (out_valid8 !== 1'b1 || codeword8 !== exp_cw || in_ready8 !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold[%0d] vld=%b cw=%h rdy=%b exp 1 %h 0", c, out_valid8, codeword8, in_ready8, exp_cw); end
      in_valid8 = 1'($urandom_range(0, 1)); info8 = 4'($urandom);
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    n_tests++; if (out_valid8 !== 1'b1 || codeword8 !== exp_cw)
      begin n_fail++; $display("FAIL bp_final vld=%b cw=%h exp 1 %h", out_valid8, codeword8, exp_cw); end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    n_tests++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1)
      begin n_fail++; $display("FAIL bp_release vld=%b rdy=%b exp 0 1", out_valid8, in_ready8); end
    repeat (3) @(negedge clk);
    n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL bp_phantom busy=%b exp=0", busy8); end
  endtask

  task automatic test_reset_mid_enc();
    int acc;
    in_valid8 = 1'b1; info8 = 4'b0110;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || codeword8 !== 8'h00)
      begin n_fail++; $display("FAIL midrst_state rdy=%b vld=%b busy=%b cw=%h exp 1 0 0 00", in_ready8, out_valid8, busy8, codeword8); end
    in_valid8 = 1'b1; info8 = 4'b0001;
    @(negedge clk);
    in_valid8 = 1'b0; acc = cyc;
    for (int t = 0; t < 20 && out_valid8 !== 1'b1; t++) @(negedge clk);
    n_tests++; if (out_valid8 !== 1'b1 || codeword8 !== 8'h0F || cyc - acc !== 3)
      begin n_fail++; $display("FAIL midrst_fresh vld=%b cw=%h lat=%0d exp 1 0f 3", out_valid8, codeword8, cyc - acc); end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_random_sweep();
    int           order [16];
    logic [7:0]   exp_q [$];
    logic [7:0]   e;
    int           n_out;
    int           j, tmp;
    bit           done_w;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    n_out = 0;
    for (int w = 0; w < 16; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL sweep_ready[%0d] got=%b exp=1", w, in_ready8); end
      in_valid8 = 1'b1; info8 = 4'(order[w]);
      exp_q.push_back(8'(model_encode(8, MASK8, 16'(order[w]))));
      @(negedge clk);
      in_valid8 = 1'b0;
      done_w = 1'b0;
      for (int t = 0; t < 60 && !done_w; t++) begin
        if (out_valid8 === 1'b1 && $urandom_range(0, 1) == 1) begin
          e = exp_q.pop_front();
          n_out++;
          n_tests++; if (codeword8 !== e) begin n_fail++; $display("FAIL sweep_codeword[%0d] info=%h got=%h exp=%h", w, order[w], codeword8, e); end
          in_valid8 = 1'b0; out_ready8 = 1'b1;
          @(negedge clk);
          out_ready8 = 1'b0;
          done_w = 1'b1;
        end else begin
          in_valid8 = 1'($urandom_range(0, 1)); info8 = 4'($urandom);
          @(negedge clk);
          in_valid8 = 1'b0;
        end
      end
      n_tests++; if (!done_w) begin n_fail++; $display("FAIL sweep_timeout[%0d] vld=%b exp=1", w, out_valid8); end
    end
    n_tests++; if (n_out !== 16 || exp_q.size() !== 0)
      begin n_fail++; $display("FAIL sweep_count got=%0d left=%0d exp 16 0", n_out, exp_q.size()); end
    repeat (5) @(negedge clk);
    n_tests++; if (out_valid8 !== 1'b0 || busy8 !== 1'b0)
      begin n_fail++; $display("FAIL sweep_extra vld=%b busy=%b exp 0 0", out_valid8, busy8); end
  endtask

  task automatic test_param_n16();
    logic [7:0]  infos [2];
    logic [15:0] e;
    int          acc;
    infos[0] = 8'hFF;
    infos[1] = 8'($urandom);
    for (int w = 0; w < 2; w++) begin
      e = model_encode(16, MASK16, 16'(infos[w]));
      in_valid16 = 1'b1; info16 = infos[w];
      @(negedge clk);
      in_valid16 = 1'b0; acc = cyc;
      for (int t = 0; t < 20 && out_valid16 !== 1'b1; t++) @(negedge clk);
      n_tests++; if (out_valid16 !== 1'b1 || cyc - acc !== 4)
        begin n_fail++; $display("FAIL n16_latency[%0d] vld=%b lat=%0d exp 1 4", w, out_valid16, cyc - acc); end
      n_tests++; if (codeword16 !== e) begin n_fail++; $display("FAIL n16_codeword[%0d] info=%h got=%h exp=%h", w, infos[w], codeword16, e); end
      out_ready16 = 1'b1;
      @(negedge clk);
      out_ready16 = 1'b0;
      n_tests++; if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL n16_release[%0d] rdy=%b exp=1", w, in_ready16); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_enc();
    test_random_sweep();
    test_param_n16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
